// File: rtl/pixel_sink.sv
// Plot-port receiver: buffers clipped pixels in a FIFO and issues held framebuffer writes.
// Optional `PIXEL_SINK_DROP_CNT_EN` adds a saturating dropped-plot counter output.
module pixel_sink #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 16,
    parameter int COLOR_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic [COLOR_BITS-1:0] color,
    input  logic                  plot,
    output logic                  ready,
    output logic [16:0]           fb_addr,
    output logic [COLOR_BITS-1:0] fb_data,
    output logic                  fb_we,
    input  logic                  fb_wait,
    output logic                  idle
`ifdef PIXEL_SINK_DROP_CNT_EN
    ,
    output logic [15:0]           dropped_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [9:0]       WIDTH_L   = 10'(WIDTH);
    localparam logic [9:0]       HEIGHT_L  = 10'(HEIGHT);
    localparam logic [16:0]      WIDTH_17  = 17'(WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [9:0]            px;
        logic [9:0]            py;
        logic [COLOR_BITS-1:0] pc;
    } pixel_t;

    typedef enum logic {
        ST_EMPTY,
        ST_PENDING
    } state_t;

    pixel_t fifo_mem [FIFO_DEPTH];
    pixel_t head;
    pixel_t incoming;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    state_t                state_q, state_d;
    logic [16:0]           addr_q, addr_d;
    logic [COLOR_BITS-1:0] data_q, data_d;

    logic in_range;
    logic push;
    logic pop;
    logic fifo_empty;

    assign incoming   = '{px: x, py: y, pc: color};
    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign in_range   = (x < WIDTH_L) && (y < HEIGHT_L);

    // ready reflects registered occupancy only, so a same-cycle pop never frees a full FIFO
    assign ready = (count_q < DEPTH_C);
    assign push  = plot && ready && in_range;
    assign pop   = !fifo_empty && ((state_q == ST_EMPTY) || !fb_wait);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (pop) begin
            state_d = ST_PENDING;
            addr_d  = 17'(head.py) * WIDTH_17 + 17'(head.px);
            data_d  = head.pc;
        end else if ((state_q == ST_PENDING) && !fb_wait) begin
            state_d = ST_EMPTY;
        end
    end

    // Storage has no reset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= incoming;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_EMPTY;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign fb_we   = (state_q == ST_PENDING);
    assign fb_addr = addr_q;
    assign fb_data = data_q;
    assign idle    = fifo_empty && (state_q == ST_EMPTY);

`ifdef PIXEL_SINK_DROP_CNT_EN
    logic [15:0] dropped_count_q, dropped_count_d;
    logic        drop;

    // Clipped and overflowed plots both count; the counter sticks at all-ones
    assign drop = plot && !push;

    always_comb begin
        dropped_count_d = dropped_count_q;
        if (drop && (dropped_count_q != 16'hFFFF)) begin
            dropped_count_d = dropped_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dropped_count_q <= '0;
        end else begin
            dropped_count_q <= dropped_count_d;
        end
    end

    assign dropped_count = dropped_count_q;
`endif

endmodule

// File: doc/pixel_sink.md
# pixel_sink

Receiving end of the draw controller's plot interface. Accepts single-cycle `plot` strobes carrying `x`/`y`/`color` and buffers them in a small FIFO. Converts each accepted pixel to a linear framebuffer address and issues it as a held write on a wait-stalled memory port shared with scanout. Sits between `draw_controller` and the video memory, so drawing never stalls on scanout arbitration while FIFO space remains.

## Interface
- `WIDTH`, 320, visible columns.
- `HEIGHT`, 240, visible rows.
- `FIFO_DEPTH`, 16, pixel entries buffered; power of two, at least 2.
- `COLOR_BITS`, 3, colour width.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `x`  in  10  pixel column.
- `y`  in  10  pixel row.
- `color`  in  COLOR_BITS  pixel colour.
- `plot`  in  1  one-cycle write strobe; `x`/`y`/`color` valid in the same cycle.
- `ready`  out  1  FIFO can take a pixel this cycle.
- `fb_addr`  out  17  linear address `y*WIDTH + x`.
- `fb_data`  out  COLOR_BITS  colour to write.
- `fb_we`  out  1  write request; held until accepted.
- `fb_wait`  in  1  memory stall; write completes on an edge where `fb_we`=1 and `fb_wait`=0.
- `idle`  out  1  FIFO empty and no write pending.

## Operation
- **Accept:** the pixel is pushed when `plot`=1, `ready`=1, `x`<WIDTH and `y`<HEIGHT.
- **Clip:** `plot` with an out-of-range coordinate is discarded and never enters the FIFO.
- **Overflow:** `plot` while `ready`=0 is discarded. There is no retry; the upstream block is responsible for honouring `ready`.
- **`ready`:** combinational from occupancy, equal to (count < FIFO_DEPTH). A pop in the same cycle does not raise `ready` while full.
- **Output register states:**
  - EMPTY: `fb_we`=0.
  - PENDING: `fb_we`=1; `fb_addr`/`fb_data` held stable.
- **EMPTY → PENDING:** when the FIFO is non-empty; the head is popped and the address is computed into the register.
- **PENDING → PENDING with new head:** when `fb_wait`=0 and the FIFO is non-empty. This gives back-to-back writes at one per cycle.
- **PENDING → EMPTY:** when `fb_wait`=0 and the FIFO is empty.
- **PENDING hold:** while `fb_wait`=1, the register holds and nothing pops.
- **Ordering:** strict FIFO. Duplicate coordinates are written in arrival order.
- **Address arithmetic:** `y*WIDTH + x` is computed at 17 bits. With in-range inputs the maximum is 76799, so no overflow is possible.
- **Simultaneous push and pop:** occupancy is unchanged and both operations take effect.
- **`idle`:** equals (count==0 and state==EMPTY).

## Timing
- **Reset:** asynchronous, taking effect immediately regardless of `clk`.
  - Output values during and after reset: `fb_we`=0, `fb_addr`=0, `fb_data`=0, `ready`=1, `idle`=1.
  - FIFO pointers and count are cleared.
- **Reset mid-operation:** queued and pending pixels are lost and no partial write is retried. `fb_we` falls asynchronously.
- **Latency:** with the sink idle and `fb_wait`=0, an accepted `plot` in cycle N gives `fb_we`=1 in cycle N+2, and the write completes at the end of N+2.
- **Throughput:** one pixel per cycle sustained when `fb_wait`=0.
- **Stall:** each cycle of `fb_wait`=1 while PENDING delays all queued pixels by one cycle.
- **Full:** the FIFO fills after FIFO_DEPTH accepts without pops. `ready` drops in the cycle after the last accepted push.
- **Wrap-around:** read and write pointers wrap modulo FIFO_DEPTH with no bubble.

## Configuration
- `PIXEL_SINK_DROP_CNT_EN` defined:
  - Adds output `dropped_count` [15:0], reset to 0.
  - Increments by 1 for every discarded `plot`, whether from clip or overflow.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- **Reset:** assert `reset_n`=0 mid-stream → `fb_we`=0, `fb_addr`=0, `fb_data`=0, `ready`=1 and `idle`=1 immediately, without waiting for a clock edge. After release, no stale write ever appears.
- **Single pixel:** `plot` x=5, y=3, color=3'b101 at cycle N, `fb_wait`=0 → in cycle N+2, `fb_we`=1, `fb_addr`=965, `fb_data`=3'b101. `idle` returns to 1 in N+3.
- **Clip:** `plot` x=320, y=0 and then x=0, y=240 → no `fb_we` ever asserts and `idle` stays 1. With `PIXEL_SINK_DROP_CNT_EN`, `dropped_count`=2.
- **Full with stall:** hold `fb_wait`=1 and issue 20 consecutive `plot` pixels → `ready`=0 after the FIFO and output register fill, and the excess pixels are dropped. Release `fb_wait` → exactly the accepted pixels are written in order, one per cycle.
- **Back-to-back with corner address:** stream 40 pixels with `fb_wait`=0 → 40 consecutive `fb_we` cycles with addresses matching `y*320+x`. Include x=319, y=239 → `fb_addr`=76799.
- **Stall mid-stream:** pulse `fb_wait` high for 3 cycles during a stream → `fb_addr`/`fb_data` stay stable for those 3 cycles, and no pixel is lost or reordered.
